// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the runtime-programmable clock divider:
//   - controller state encoding (STOP / RUN / PEND)
//   - default counter width and divisor limits
// -----------------------------------------------------------------------------
package clk_div_pkg;

  // STOP: divider idle, counter held at 0
  // RUN : dividing with the active divisor
  // PEND: dividing, a new divisor waits for the next period boundary
  typedef enum logic [1:0] {
    ST_STOP = 2'b00,
    ST_RUN  = 2'b01,
    ST_PEND = 2'b10
  } state_e;

  localparam int CNT_W_DEF       = 28;
  localparam int DEFAULT_DIV_DEF = 2;
  localparam int MIN_DIV_DEF     = 2;

endpackage

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
// Divide counter with period wrap and registered o_clk/o_tick decode.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   run_i          : divider running (RUN or PEND)
//   clr_i          : force the counter back to 0 on the next edge
//   div_i          : active divisor (>= 2)
//   half_i         : div_i >> 1, precomputed by the controller
//   boundary_o     : last cycle of the current period (combinational)
//   clk_o, tick_o  : divided clock and its rising-edge tick (registered)
// -----------------------------------------------------------------------------
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             run_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             boundary_o,
  output logic             clk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             at_end;

  assign at_end     = (cnt_q == (div_i - CNT_W'(1)));
  assign boundary_o = run_i & at_end;

  // Next counter value and output decode of the current count
  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = run_i & (cnt_q < half_i);
    tick_d = run_i & (cnt_q == '0);
    if (!run_i || clr_i || at_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Start/stop and divisor-change sequencing for the divider so that o_clk
// never produces a runt pulse. New divisors arrive over a valid/ready
// handshake and take effect only at a period boundary (or at once in STOP).
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_enable       : 1 = run, 0 = stop at the next period boundary
//   i_div          : requested divisor
//   i_div_valid    : request strobe
//   o_div_ready    : request can be accepted this cycle (not in PEND)
//   o_div_ack      : one-cycle pulse when a divisor takes effect
//   o_err          : one-cycle pulse when a request below MIN_DIV is rejected
//   o_active_div   : divisor in use
//   o_running      : RUN or PEND (including draining)
//   o_clk, o_tick  : divided clock and its rising-edge tick
// -----------------------------------------------------------------------------
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
  parameter int MIN_DIV     = MIN_DIV_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_div,
  input  logic             i_div_valid,
  output logic             o_div_ready,
  output logic             o_div_ack,
  output logic             o_err,
  output logic [CNT_W-1:0] o_active_div,
  output logic             o_running,
  output logic             o_clk,
  output logic             o_tick
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             stop_req_q, stop_req_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             accept;
  logic             good;
  logic             bad;
  logic             stopping;
  logic             boundary;
  logic             run;
  logic             clr;

  assign run      = (state_q != ST_STOP);
  assign accept   = i_div_valid & o_div_ready;
  assign bad      = accept & (i_div < CNT_W'(MIN_DIV));
  assign good     = accept & ~bad;
  // Enable dropping on the boundary cycle itself still stops at that boundary.
  assign stopping = stop_req_q | ~i_enable;
  assign clr      = (state_d == ST_STOP);

  // Next-state, divisor bookkeeping and pulse generation
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pend_d     = pend_q;
    stop_req_d = stop_req_q;
    ack_d      = 1'b0;
    err_d      = bad;
    case (state_q)
      ST_STOP: begin
        stop_req_d = 1'b0;
        if (good) begin
          active_d = i_div;
          ack_d    = 1'b1;
        end else begin
          active_d = active_q;
        end
        if (i_enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_RUN: begin
        stop_req_d = ~i_enable;
        if (boundary && stopping) begin
          // Nothing would carry a pending divisor through STOP, so a
          // request landing on the final boundary is applied right away.
          state_d    = ST_STOP;
          stop_req_d = 1'b0;
          if (good) begin
            active_d = i_div;
            ack_d    = 1'b1;
          end else begin
            active_d = active_q;
          end
        end else if (good) begin
          // Also taken on a boundary cycle: applied at the following one.
          pend_d  = i_div;
          state_d = ST_PEND;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PEND: begin
        stop_req_d = ~i_enable;
        if (boundary) begin
          active_d = pend_q;
          ack_d    = 1'b1;
          if (stopping) begin
            state_d    = ST_STOP;
            stop_req_d = 1'b0;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_PEND;
        end
      end
      default: begin
        state_d    = ST_STOP;
        stop_req_d = 1'b0;
      end
    endcase
    half_d = active_d >> 1'b1;
  end

  // Controller registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_STOP;
      active_q   <= CNT_W'(DEFAULT_DIV);
      half_q     <= CNT_W'(DEFAULT_DIV) >> 1'b1;
      pend_q     <= '0;
      stop_req_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      stop_req_q <= stop_req_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i      (i_clk),
    .reset_i    (i_reset),
    .run_i      (run),
    .clr_i      (clr),
    .div_i      (active_q),
    .half_i     (half_q),
    .boundary_o (boundary),
    .clk_o      (o_clk),
    .tick_o     (o_tick)
  );

  assign o_div_ready  = (state_q != ST_PEND);
  assign o_running    = run;
  assign o_div_ack    = ack_q;
  assign o_err        = err_q;
  assign o_active_div = active_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Scoreboard bench: the driver applies inputs on the falling edge, steps a
// behavioural model and queues the outputs expected after the next rising
// edge; a monitor pops and compares 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

  localparam int W = 28;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         v;
  logic [W-1:0] d;
  logic         rdy_o, ack_o, err_o, run_o, clk_o, tick_o;
  logic [W-1:0] act_o;

  typedef struct {
    logic         clk;
    logic         tick;
    logic         ack;
    logic         err;
    logic         run;
    logic         rdy;
    logic [W-1:0] act;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Behavioural model: position within the period and the divisors in play
  bit   m_run  = 1'b0;
  bit   m_pend = 1'b0;
  bit   m_stop = 1'b0;
  int   m_pos  = 0;
  int   m_div  = 2;
  int   m_pdiv = 0;

  clk_div_ctrl #(.CNT_W(W), .DEFAULT_DIV(2), .MIN_DIV(2)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_div        (d),
    .i_div_valid  (v),
    .o_div_ready  (rdy_o),
    .o_div_ack    (ack_o),
    .o_err        (err_o),
    .o_active_div (act_o),
    .o_running    (run_o),
    .o_clk        (clk_o),
    .o_tick       (tick_o)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit e, input bit vv, input int dd, input bit r,
                            output exp_t x);
    bit acc, good, bnd, stopping;
    if (r) begin
      m_run = 0; m_pos = 0; m_div = 2; m_pend = 0; m_stop = 0;
      x.clk = 0; x.tick = 0; x.ack = 0; x.err = 0;
    end else begin
      // Outputs decode the position held before this edge
      x.clk  = m_run && (m_pos < m_div / 2);
      x.tick = m_run && (m_pos == 0);
      x.ack  = 0;
      acc    = vv && !m_pend;
      x.err  = acc && (dd < 2);
      good   = acc && (dd >= 2);
      if (!m_run) begin
        if (good) begin m_div = dd; x.ack = 1; end
        if (e) m_run = 1;
        m_pos = 0; m_stop = 0;
      end else begin
        bnd      = (m_pos == m_div - 1);
        stopping = m_stop || !e;
        m_stop   = !e;
        if (bnd) begin
          m_pos = 0;
          if (m_pend) begin m_div = m_pdiv; m_pend = 0; x.ack = 1; end
          if (good && stopping) begin m_div = dd; x.ack = 1; end
          else if (good) begin m_pend = 1; m_pdiv = dd; end
          if (stopping) begin m_run = 0; m_stop = 0; end
        end else begin
          m_pos = m_pos + 1;
          if (good) begin m_pend = 1; m_pdiv = dd; end
        end
      end
    end
    x.run = m_run;
    x.rdy = !m_pend;
    x.act = W'(m_div);
  endtask

  task automatic step(input bit e, input bit vv, input int dd, input bit r);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; v = vv; d = W'(dd);
    model_step(e, vv, dd, r, x);
    q.push_back(x);
  endtask

  // Run with enable e until the model reaches position p while running
  task automatic wait_pos(input int p, input bit e);
    int i;
    i = 0;
    while (!(m_run && m_pos == p) && i < 40) begin
      step(e, 0, 0, 0);
      i++;
    end
    n_tests++;
    if (!(m_run && m_pos == p)) begin
      n_fail++;
      $display("FAIL wait_pos: position %0d not reached (got %0d, run %0d)", p, m_pos, m_run);
    end
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every queued expectation against the DUT outputs
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_x = q.pop_front();
      chk("o_clk",        W'(clk_o),  W'(mon_x.clk));
      chk("o_tick",       W'(tick_o), W'(mon_x.tick));
      chk("o_div_ack",    W'(ack_o),  W'(mon_x.ack));
      chk("o_err",        W'(err_o),  W'(mon_x.err));
      chk("o_running",    W'(run_o),  W'(mon_x.run));
      chk("o_div_ready",  W'(rdy_o),  W'(mon_x.rdy));
      chk("o_active_div", act_o,      mon_x.act);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit e, vv, r;
    int dd;
    rst = 1'b1; en = 1'b0; v = 1'b0; d = '0;
    // Reset, then run at the default divisor and stop
    repeat (3) step(0, 0, 0, 1);
    repeat (8) step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    // Divisor 4 loaded in STOP, then run
    step(0, 1, 4, 0);
    step(0, 0, 0, 0);
    repeat (12) step(1, 0, 0, 0);
    // Change to 5 mid-period
    wait_pos(1, 1);
    step(1, 1, 5, 0);
    repeat (16) step(1, 0, 0, 0);
    // Illegal divisors
    step(1, 1, 1, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (6) step(1, 0, 0, 0);
    // Divisor 6, then drop enable at counter 2
    step(1, 1, 6, 0);
    repeat (14) step(1, 0, 0, 0);
    wait_pos(2, 1);
    repeat (10) step(0, 0, 0, 0);
    // Second run: enable low briefly, back high at counter 3
    step(1, 0, 0, 0);
    wait_pos(1, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    repeat (14) step(1, 0, 0, 0);
    // Reset while divisor 8 is pending
    wait_pos(1, 1);
    step(1, 1, 8, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    repeat (10) step(0, 0, 0, 0);
    repeat (6) step(1, 0, 0, 0);
    // Randomized traffic
    repeat (600) begin
      e  = ($urandom_range(0, 9) != 0);
      vv = ($urandom_range(0, 5) == 0);
      dd = $urandom_range(0, 9);
      r  = ($urandom_range(0, 199) == 0);
      step(e, vv, dd, r);
    end
    repeat (2) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
